freq_meter: RTL and testbench



---
 rtl/freq_meter.sv | 152 +++++++++++++++
 tb/tb_freq_meter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Period / high-time meter for a slow signal sampled on the system clock.
// Results use a valid/ready handshake and carry sticky overrun and no-edge timeout flags.
module freq_meter #(
   parameter int CNT_W   = 27,
   parameter int TIMEOUT = 120000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   input  logic             ready,
   output logic             overrun,
   input  logic             clr_ovr,
   output logic             timeout,
   output logic             busy
);

   typedef enum logic [0:0] {
      ARM  = 1'b0,
      MEAS = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic             s1;
   logic             s2;
   logic             s3;
   logic             rise;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt_nxt;
   logic [CNT_W-1:0] high_cnt_nxt;
   logic             capture;
   logic             tmo_hit;

   assign rise = s2 & ~s3;
   assign busy = (state == MEAS);

   // Two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARM;
         period_cnt <= '0;
         high_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         period_cnt <= period_cnt_nxt;
         high_cnt   <= high_cnt_nxt;
      end
   end

   // Next state, counter updates, capture and timeout strobes
   always_comb begin
      state_nxt      = state;
      period_cnt_nxt = '0;
      high_cnt_nxt   = '0;
      capture        = 1'b0;
      tmo_hit        = 1'b0;
      if (!en) begin
         state_nxt = ARM;
      end else begin
         case (state)
            ARM: begin
               if (rise) begin
                  state_nxt      = MEAS;
                  period_cnt_nxt = CNT_ONE;
                  high_cnt_nxt   = CNT_ONE;
               end else begin
                  state_nxt = ARM;
               end
            end
            MEAS: begin
               if (rise) begin
                  capture        = 1'b1;
                  period_cnt_nxt = CNT_ONE;
                  high_cnt_nxt   = CNT_ONE;
               end else if (period_cnt == TMO_LAST) begin
                  // The unfinished period is discarded; re-arm on the next edge.
                  tmo_hit   = 1'b1;
                  state_nxt = ARM;
               end else begin
                  period_cnt_nxt = period_cnt + CNT_ONE;
                  high_cnt_nxt   = high_cnt + {{(CNT_W-1){1'b0}}, s2};
               end
            end
            default: begin
               state_nxt = ARM;
            end
         endcase
      end
   end

   // Result registers and handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
      end else if (capture) begin
         period    <= period_cnt;
         high_time <= high_cnt;
         valid     <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

   // Sticky flags: a new overrun beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
         timeout <= 1'b0;
      end else begin
         if (capture && valid && !ready) begin
            overrun <= 1'b1;
         end else if (clr_ovr) begin
            overrun <= 1'b0;
         end else begin
            overrun <= overrun;
         end
         if (capture) begin
            timeout <= 1'b0;
         end else if (tmo_hit) begin
            timeout <= 1'b1;
         end else begin
            timeout <= timeout;
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter against a rise-time based reference model.
module tb_freq_meter;

   localparam int CW  = 27;
   localparam int TMO = 1000;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          sig_in;
   logic          ready;
   logic          clr_ovr;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          valid;
   logic          overrun;
   logic          timeout;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // Model: samp[j] is sig_in as seen at the j-th clock edge after reset release.
   bit samp [0:32767];
   int k;
   bit meas;
   int r0;
   int x_period;
   int x_high;
   bit x_valid;
   bit x_ovr;
   bit x_tmo;
   bit x_busy;

   freq_meter #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .ready     (ready),
      .overrun   (overrun),
      .clr_ovr   (clr_ovr),
      .timeout   (timeout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, k);
      end
   endtask

   function automatic bit sa(input int j);
      return (j < 1) ? 1'b0 : samp[j];
   endfunction

   task automatic model_reset();
      k        = 0;
      meas     = 1'b0;
      r0       = 0;
      x_period = 0;
      x_high   = 0;
      x_valid  = 1'b0;
      x_ovr    = 1'b0;
      x_tmo    = 1'b0;
      x_busy   = 1'b0;
   endtask

   // Synchronized sig is the input two edges late; a rise in cycle t ends the
   // period begun at the previous rise r0 and lasts t-r0 cycles.
   task automatic model_step(input bit e, input bit r, input bit c);
      int  t;
      bit  rise;
      bit  cap;
      bit  tmo;
      int  per;
      int  hi;
      t    = k;
      rise = sa(t - 1) && !sa(t - 2);
      cap  = 1'b0;
      tmo  = 1'b0;
      per  = 0;
      hi   = 0;
      if (!e) begin
         meas = 1'b0;
      end else if (!meas) begin
         if (rise) begin
            meas = 1'b1;
            r0   = t;
         end
      end else if (rise) begin
         cap = 1'b1;
         per = t - r0;
         for (int c2 = r0; c2 < t; c2++) hi += int'(sa(c2 - 1));
         r0 = t;
      end else if (t - r0 == TMO - 1) begin
         tmo  = 1'b1;
         meas = 1'b0;
      end
      if (cap) begin
         if (x_valid && !r) x_ovr = 1'b1;
         else if (c) x_ovr = 1'b0;
         x_period = per;
         x_high   = hi;
         x_valid  = 1'b1;
         x_tmo    = 1'b0;
      end else begin
         if (x_valid && r) x_valid = 1'b0;
         if (c) x_ovr = 1'b0;
         if (tmo) x_tmo = 1'b1;
      end
      x_busy = meas;
   endtask

   // Entered at a negedge: compare, drive the next inputs, advance the model.
   task automatic cyc(input bit s, input bit e, input bit r, input bit c);
      check_eq("period", 32'(period), 32'(x_period));
      check_eq("high_time", 32'(high_time), 32'(x_high));
      check_eq("valid", 32'(valid), 32'(x_valid));
      check_eq("overrun", 32'(overrun), 32'(x_ovr));
      check_eq("timeout", 32'(timeout), 32'(x_tmo));
      check_eq("busy", 32'(busy), 32'(x_busy));
      sig_in  = s;
      en      = e;
      ready   = r;
      clr_ovr = c;
      model_step(e, r, c);
      if (k < 32766) k++;
      samp[k] = s;
      @(negedge clk);
   endtask

   task automatic wave(input int p, input int h, input int n,
                       input int rdy_pct, input int clr_pct, input int en_pct);
      bit e;
      bit r;
      bit c;
      for (int i = 0; i < n; i++) begin
         e = ($urandom_range(0, 99) >= en_pct);
         r = ($urandom_range(0, 99) < rdy_pct);
         c = ($urandom_range(0, 99) < clr_pct);
         cyc((i % p) < h, e, r, c);
      end
   endtask

   initial begin
      int p;
      int h;
      rst     = 1'b1;
      en      = 1'b0;
      sig_in  = 1'b0;
      ready   = 1'b0;
      clr_ovr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Arm and measure, then a narrow pulse
      wave(10, 5, 60, 100, 0, 0);
      check_eq("p_5_5", 32'(period), 32'd10);
      check_eq("h_5_5", 32'(high_time), 32'd5);
      wave(20, 3, 100, 100, 0, 0);
      check_eq("p_3_17", 32'(period), 32'd20);
      check_eq("h_3_17", 32'(high_time), 32'd3);
      check_eq("ovr_3_17", 32'(overrun), 32'd0);

      // Backpressure, release and overrun clear
      wave(10, 5, 35, 0, 0, 0);
      check_eq("bp_valid", 32'(valid), 32'd1);
      check_eq("bp_ovr", 32'(overrun), 32'd1);
      check_eq("bp_period", 32'(period), 32'd10);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("ovr_clr", 32'(overrun), 32'd0);

      // Timeout after the signal stops, cleared by the next capture
      wave(10, 5, 40, 100, 0, 0);
      for (int i = 0; i < TMO + 50; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("tmo_set", 32'(timeout), 32'd1);
      check_eq("tmo_busy", 32'(busy), 32'd0);
      wave(10, 5, 40, 100, 0, 0);
      check_eq("tmo_clr", 32'(timeout), 32'd0);

      // Enable dropped mid-period
      wave(10, 5, 23, 100, 0, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      wave(10, 5, 40, 100, 0, 0);

      // Random shapes, backpressure, clears and rare enable drops
      for (int n = 0; n < 6; n++) begin
         p = int'($urandom_range(4, 60));
         h = int'($urandom_range(1, p - 1));
         wave(p, h, 4 * p, 70, 5, 2);
      end

      // Asynchronous reset mid-period
      wave(10, 5, 15, 100, 0, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_period", 32'(period), 32'd0);
      check_eq("arst_high", 32'(high_time), 32'd0);
      check_eq("arst_valid", 32'(valid), 32'd0);
      check_eq("arst_ovr", 32'(overrun), 32'd0);
      check_eq("arst_tmo", 32'(timeout), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Long period, 50% duty
      wave(50, 25, 400, 100, 0, 0);
      check_eq("p_50", 32'(period), 32'd50);
      check_eq("h_50", 32'(high_time), 32'd25);
      check_eq("tmo_50", 32'(timeout), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
